// File: rtl/t03_vga_ctrl.sv
// Pixel/line timing generator with a per-line framebuffer fetch handshake (IDLE/REQ/BUSY).
// Underrun detection is built only when T03_VGA_UNDERRUN_DET_EN is defined.
module t03_vga_ctrl #(
    parameter int H_TOTAL     = 200,
    parameter int V_TOTAL     = 640,
    parameter int H_ACT_START = 37,
    parameter int V_ACT_START = 29,
    parameter int V_ACT_END   = 629,
    parameter int CLK_DIV     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fetch_ack,
    input  logic        fetch_done,
    input  logic        underrun_clr,
    output logic [10:0] Hcnt,
    output logic [10:0] Vcnt,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        fetch_req,
    output logic [9:0]  fetch_row,
    output logic        fetch_abort,
    output logic        underrun
);
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_REQ   = 2'd1;
    localparam logic [1:0]  ST_BUSY  = 2'd2;
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_S  = 11'(V_ACT_START);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACT_END);

    logic [3:0]  r_div;
    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic [1:0]  r_state;
    logic [9:0]  r_fetch_row;
    logic        r_frame_start;
    logic        r_fetch_abort;

    logic        w_tick;
    logic        w_hwrap;
    logic        w_vwrap;
    logic        w_line_evt;
    logic [10:0] w_hcnt_nxt;
    logic [10:0] w_vcnt_nxt;

    // Tick is gated by rst so CLK_DIV=1 cannot show a pulse while held in reset.
    assign w_tick     = en && (r_div == DIV_LAST) && !rst;
    assign w_hwrap    = (r_hcnt == H_LAST);
    assign w_vwrap    = (r_vcnt == V_LAST);
    assign w_hcnt_nxt = w_hwrap ? 11'd0 : r_hcnt + 11'd1;
    assign w_vcnt_nxt = w_hwrap ? (w_vwrap ? 11'd0 : r_vcnt + 11'd1) : r_vcnt;
    assign w_line_evt = w_tick && w_hwrap && (w_vcnt_nxt >= V_ACT_S) && (w_vcnt_nxt <= V_ACT_E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (en) begin
                r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
            end
            if (w_tick) begin
                r_hcnt        <= w_hcnt_nxt;
                r_vcnt        <= w_vcnt_nxt;
                r_frame_start <= w_hwrap && w_vwrap;
            end
        end
    end

    // A new line event always restarts the fetch, aborting whatever was outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fetch_row   <= '0;
            r_fetch_abort <= 1'b0;
        end else begin
            r_fetch_abort <= 1'b0;
            if (w_line_evt) begin
                r_fetch_abort <= (r_state != ST_IDLE);
                r_state       <= ST_REQ;
                r_fetch_row   <= 10'(w_vcnt_nxt - V_ACT_S);
            end else begin
                case (r_state)
                    ST_REQ:  if (fetch_ack)  r_state <= ST_BUSY;
                    ST_BUSY: if (fetch_done) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef T03_VGA_UNDERRUN_DET_EN
    localparam logic [10:0] H_ACT = 11'(H_ACT_START);

    logic r_underrun;
    logic w_urun_set;

    assign w_urun_set = w_tick && (w_hcnt_nxt == H_ACT) && (r_state != ST_IDLE)
                        && (w_vcnt_nxt >= V_ACT_S) && (w_vcnt_nxt <= V_ACT_E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end else if (w_urun_set) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = r_underrun;
`else
    logic [11:0] w_unused_urun;

    assign w_unused_urun = {underrun_clr, 11'(H_ACT_START)};
    assign underrun      = 1'b0;
`endif

    assign Hcnt        = r_hcnt;
    assign Vcnt        = r_vcnt;
    assign pixel_tick  = w_tick;
    assign frame_start = r_frame_start;
    assign fetch_req   = (r_state == ST_REQ);
    assign fetch_row   = r_fetch_row;
    assign fetch_abort = r_fetch_abort;

endmodule

// File: tb/tb_t03_vga_ctrl.sv
// Directed bench for t03_vga_ctrl: vector table over one long run plus reset/freeze sequences.
module tb_t03_vga_ctrl;

`ifdef T03_VGA_UNDERRUN_DET_EN
    localparam bit URUN_ON = 1'b1;
`else
    localparam bit URUN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        man_ack;
    logic        man_done;
    logic        clr;
    logic        srv_on;
    logic        srv_ack;
    logic        srv_done;
    logic        w_ack;
    logic        w_done;
    logic [10:0] Hcnt;
    logic [10:0] Vcnt;
    logic        pixel_tick;
    logic        frame_start;
    logic        fetch_req;
    logic [9:0]  fetch_row;
    logic        fetch_abort;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int kk       = 0;
    int fs_cnt   = 0;

    assign w_ack  = man_ack | srv_ack;
    assign w_done = man_done | srv_done;

    t03_vga_ctrl #(
        .H_TOTAL(200), .V_TOTAL(48), .H_ACT_START(37),
        .V_ACT_START(29), .V_ACT_END(45), .CLK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fetch_ack(w_ack), .fetch_done(w_done), .underrun_clr(clr),
        .Hcnt(Hcnt), .Vcnt(Vcnt), .pixel_tick(pixel_tick), .frame_start(frame_start),
        .fetch_req(fetch_req), .fetch_row(fetch_row), .fetch_abort(fetch_abort),
        .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Automatic reader: acks a pending request, reports done one cycle later.
    always @(negedge clk) begin
        if (!srv_on) begin
            srv_ack  <= 1'b0;
            srv_done <= 1'b0;
        end else begin
            srv_done <= srv_ack;
            srv_ack  <= fetch_req && !srv_ack;
        end
    end

    always @(posedge clk) begin
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string nm;
        int    k;
        bit    ack, done, clr, srv;
        int    h, v;
        bit    tk, req;
        int    row;
        bit    ab, fs, ur;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input string nm, input int k, input bit a, input bit d,
                                input bit c, input bit s, input int h, input int v,
                                input bit tk, input bit rq, input int row, input bit ab,
                                input bit fs, input bit ur);
        vec_t e;
        e.nm = nm; e.k = k; e.ack = a; e.done = d; e.clr = c; e.srv = s;
        e.h = h; e.v = v; e.tk = tk; e.req = rq; e.row = row; e.ab = ab; e.fs = fs; e.ur = ur;
        vt.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic adv_to(input int target);
        while (kk < target) begin
            @(negedge clk);
            kk++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hcnt"},  32'(Hcnt), 0);
        chk({tag, "_vcnt"},  32'(Vcnt), 0);
        chk({tag, "_tick"},  32'(pixel_tick), 0);
        chk({tag, "_fs"},    32'(frame_start), 0);
        chk({tag, "_req"},   32'(fetch_req), 0);
        chk({tag, "_row"},   32'(fetch_row), 0);
        chk({tag, "_abort"}, 32'(fetch_abort), 0);
        chk({tag, "_urun"},  32'(underrun), 0);
    endtask

    initial begin
        //        name              k      ak dn cl sv  h    v  tk rq row ab fs ur
        add("pre_l29",         11599, 0, 0, 0, 0, 199, 28, 1, 0,  0, 0, 0, 0);
        add("l29_req",         11600, 0, 0, 0, 0,   0, 29, 0, 1,  0, 0, 0, 0);
        add("l29_wait",        11603, 1, 0, 0, 0,   1, 29, 1, 1,  0, 0, 0, 0);
        add("l29_busy",        11604, 0, 0, 0, 0,   2, 29, 0, 0,  0, 0, 0, 0);
        add("l29_done",        11610, 0, 1, 0, 0,   5, 29, 0, 0,  0, 0, 0, 0);
        add("l29_idle",        11611, 0, 0, 0, 0,   5, 29, 1, 0,  0, 0, 0, 0);
        add("l29_h38",         11676, 0, 0, 0, 0,  38, 29, 0, 0,  0, 0, 0, 0);
        add("l30_req",         12000, 0, 0, 0, 0,   0, 30, 0, 1,  1, 0, 0, 0);
        add("l30_ack",         12001, 1, 0, 0, 0,   0, 30, 1, 1,  1, 0, 0, 0);
        add("l30_busy",        12002, 0, 0, 0, 0,   1, 30, 0, 0,  1, 0, 0, 0);
        add("l30_h36",         12073, 0, 0, 0, 0,  36, 30, 1, 0,  1, 0, 0, 0);
        add("l30_urun",        12074, 0, 0, 0, 0,  37, 30, 0, 0,  1, 0, 0, 1);
        add("l31_abort",       12400, 0, 0, 0, 0,   0, 31, 0, 1,  2, 1, 0, 1);
        add("l31_once",        12401, 0, 0, 0, 0,   0, 31, 1, 1,  2, 0, 0, 1);
        add("l31_sticky",      12473, 0, 0, 1, 0,  36, 31, 1, 1,  2, 0, 0, 1);
        add("l31_clr",         12474, 0, 0, 0, 0,  37, 31, 0, 1,  2, 0, 0, 0);
        add("l31_stay",        12475, 0, 0, 0, 0,  37, 31, 1, 1,  2, 0, 0, 0);
        add("l31_done_in_req", 12480, 0, 1, 0, 0,  40, 31, 0, 1,  2, 0, 0, 0);
        add("l31_done_ign",    12481, 0, 0, 0, 0,  40, 31, 1, 1,  2, 0, 0, 0);
        add("l31_ack",         12490, 1, 0, 0, 0,  45, 31, 0, 1,  2, 0, 0, 0);
        add("l31_busy",        12491, 0, 1, 0, 0,  45, 31, 1, 0,  2, 0, 0, 0);
        add("l31_idle",        12492, 0, 0, 0, 1,  46, 31, 0, 0,  2, 0, 0, 0);
        add("l39_served",      15700, 0, 0, 0, 0,  50, 39, 0, 0, 10, 0, 0, 0);
        add("l40_req",         16000, 0, 0, 0, 0,   0, 40, 0, 1, 11, 0, 0, 0);
        add("l40_end",         16399, 0, 0, 0, 0, 199, 40, 1, 1, 11, 0, 0, 1);
        add("l41_abort",       16400, 0, 0, 0, 0,   0, 41, 0, 1, 12, 1, 0, 1);
        add("l41_once",        16401, 0, 0, 0, 1,   0, 41, 1, 1, 12, 0, 0, 1);
        add("l45_req",         18000, 0, 0, 0, 1,   0, 45, 0, 1, 16, 0, 0, 1);
        add("l46_none",        18400, 0, 0, 0, 1,   0, 46, 0, 0, 16, 0, 0, 1);
        add("f0_last",         19199, 0, 0, 0, 1, 199, 47, 1, 0, 16, 0, 0, 1);
        add("f0_wrap",         19200, 0, 0, 0, 1,   0,  0, 0, 0, 16, 0, 1, 1);
        add("f0_fs_end",       19201, 0, 0, 0, 1,   0,  0, 1, 0, 16, 0, 0, 1);
        add("f1_last",         38399, 0, 0, 0, 1, 199, 47, 1, 0, 16, 0, 0, 1);
        add("f1_wrap",         38400, 0, 0, 0, 1,   0,  0, 0, 0, 16, 0, 1, 1);
        add("f2_pre29",        49999, 0, 0, 0, 0, 199, 28, 1, 0, 16, 0, 0, 1);
        add("f2_l29",          50000, 0, 0, 0, 0,   0, 29, 0, 1,  0, 0, 0, 1);

        rst = 1'b1; en = 1'b1; man_ack = 1'b1; man_done = 1'b1; clr = 1'b1; srv_on = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");

        man_ack = 1'b0; man_done = 1'b0; clr = 1'b0;
        rst = 1'b0;
        kk = 0;
        chk("rel_tick0", 32'(pixel_tick), 0);
        adv_to(1);
        chk("rel_tick1", 32'(pixel_tick), 1);
        chk("rel_h0", 32'(Hcnt), 0);
        adv_to(2);
        chk("rel_h1", 32'(Hcnt), 1);
        chk("rel_tick2", 32'(pixel_tick), 0);

        adv_to(200);
        chk("frz_h100", 32'(Hcnt), 100);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("frz_hold", 32'(Hcnt), 100);
            chk("frz_notick", 32'(pixel_tick), 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("frz_res_tick", 32'(pixel_tick), 1);
        chk("frz_res_h", 32'(Hcnt), 100);
        @(negedge clk);
        chk("frz_h101", 32'(Hcnt), 101);
        kk = 202;

        foreach (vt[i]) begin
            adv_to(vt[i].k);
            chk({vt[i].nm, "_h"},     32'(Hcnt), 32'(vt[i].h));
            chk({vt[i].nm, "_v"},     32'(Vcnt), 32'(vt[i].v));
            chk({vt[i].nm, "_tick"},  32'(pixel_tick), 32'(vt[i].tk));
            chk({vt[i].nm, "_req"},   32'(fetch_req), 32'(vt[i].req));
            chk({vt[i].nm, "_row"},   32'(fetch_row), 32'(vt[i].row));
            chk({vt[i].nm, "_abort"}, 32'(fetch_abort), 32'(vt[i].ab));
            chk({vt[i].nm, "_fs"},    32'(frame_start), 32'(vt[i].fs));
            chk({vt[i].nm, "_urun"},  32'(underrun), 32'(vt[i].ur & URUN_ON));
            man_ack  = vt[i].ack;
            man_done = vt[i].done;
            clr      = vt[i].clr;
            srv_on   = vt[i].srv;
        end
        chk("fs_count", 32'(fs_cnt), 2);

        adv_to(50001);
        man_ack = 1'b1;
        adv_to(50002);
        man_ack = 1'b0;
        chk("busy_req", 32'(fetch_req), 0);
        chk("busy_h", 32'(Hcnt), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_busy");
        repeat (2) @(negedge clk);
        chk("rst_hold_h", 32'(Hcnt), 0);
        chk("rst_hold_abort", 32'(fetch_abort), 0);
        rst = 1'b0;
        chk("rel2_tick0", 32'(pixel_tick), 0);
        @(negedge clk);
        chk("rel2_tick1", 32'(pixel_tick), 1);
        chk("rel2_h0", 32'(Hcnt), 0);
        chk("rel2_req", 32'(fetch_req), 0);
        @(negedge clk);
        chk("rel2_h1", 32'(Hcnt), 1);
        chk("rel2_v0", 32'(Vcnt), 0);
        chk("rel2_abort", 32'(fetch_abort), 0);
        chk("rel2_fs_count", 32'(fs_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t03_vga_ctrl.md
T03_VGA_CTRL -- requirements
Module: t03_vga_ctrl

Interface
REQ-001 SHALL have parameter H_TOTAL, default 200: pixels per line; Hcnt counts 0..H_TOTAL-1.
REQ-002 SHALL have parameter V_TOTAL, default 640: lines per frame; Vcnt counts 0..V_TOTAL-1.
REQ-003 SHALL have parameters H_ACT_START / V_ACT_START / V_ACT_END, defaults 37 / 29 / 629: first active pixel, first active line, last active line.
REQ-004 SHALL have parameter CLK_DIV, default 2, range 1..16: clk cycles per pixel tick.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  1 = counters advance; 0 = counters and divider hold.
REQ-008 Hcnt  out  11  horizontal pixel counter, feeds the sync/display comparator.
REQ-009 Vcnt  out  11  vertical line counter, feeds the sync/display comparator.
REQ-010 pixel_tick  out  1  one-cycle pulse per pixel advance.
REQ-011 frame_start  out  1  one-cycle pulse when Hcnt and Vcnt both wrap to 0.
REQ-012 fetch_req  out  1  line-fetch request to the framebuffer reader.
REQ-013 fetch_row  out  10  row to fetch, equal to Vcnt-V_ACT_START, stable while fetch_req=1.
REQ-014 fetch_ack  in  1  reader accepted the request.
REQ-015 fetch_done  in  1  reader finished filling the line buffer.
REQ-016 fetch_abort  out  1  one-cycle pulse when an unfinished fetch is abandoned.
REQ-017 underrun  out  1  sticky flag: active pixels reached before the fetch completed.
REQ-018 underrun_clr  in  1  synchronous clear of underrun.

Function
REQ-019 Divider SHALL count 0..CLK_DIV-1 while en=1; pixel_tick=1 in the cycle the divider is at CLK_DIV-1, then the divider wraps to 0.
REQ-020 On pixel_tick, Hcnt SHALL increment and wrap from H_TOTAL-1 to 0; on that wrap, Vcnt SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-021 frame_start SHALL be asserted in the cycle after the registers reach Hcnt=0 and Vcnt=0, for one cycle.
REQ-022 en=0 SHALL freeze the divider, Hcnt and Vcnt with no pixel_tick; the fetch FSM keeps running.
REQ-023 The fetch FSM SHALL have states IDLE, REQ and BUSY.
REQ-024 A line event is a pixel_tick wrapping Hcnt to 0 where the new Vcnt is in [V_ACT_START, V_ACT_END].
REQ-025 On a line event, the FSM SHALL go to REQ and latch fetch_row.
REQ-026 In REQ, fetch_req=1; if fetch_ack=1 is sampled, the FSM SHALL go to BUSY next cycle.
REQ-027 In BUSY, the FSM SHALL go to IDLE when fetch_done=1 is sampled.
REQ-028 A fetch_done seen in IDLE or REQ SHALL be ignored.
REQ-029 If a line event occurs in REQ or BUSY, the FSM SHALL pulse fetch_abort, relatch fetch_row and go to REQ, even if fetch_ack or fetch_done is also high that cycle.
REQ-030 Underrun SHALL be set on a pixel_tick where Hcnt becomes H_ACT_START while the FSM is not IDLE and Vcnt is active.
REQ-031 underrun_clr SHALL win over a simultaneous set.

Reset
REQ-032 While rst=1, the FSM SHALL be IDLE.
REQ-033 While rst=1, Hcnt, Vcnt, the divider, fetch_row, pixel_tick, frame_start, fetch_req, fetch_abort and underrun SHALL all be 0.
REQ-034 Reset in the middle of a fetch SHALL drop fetch_req immediately, with no fetch_abort pulse.
REQ-035 The first pixel_tick after reset release SHALL occur CLK_DIV cycles after the release edge.

Configuration
REQ-036 Macro T03_VGA_UNDERRUN_DET_EN defined: underrun behaves per REQ-030/031.
REQ-037 Macro T03_VGA_UNDERRUN_DET_EN undefined: underrun is tied to 0, underrun_clr is ignored, and no detection logic is built.

Verification
REQ-038 CLK_DIV=2, en=1, run 2*200*640 cycles -> Hcnt wraps 199->0; Vcnt wraps 639->0; exactly one frame_start per frame.
REQ-039 Line event at Vcnt=29 -> fetch_req=1 with fetch_row=0; ack after 3 cycles -> BUSY; done -> IDLE; underrun stays 0.
REQ-040 Withhold fetch_done past Hcnt=37 on Vcnt=30 -> underrun=1; assert underrun_clr together with a new set -> underrun=0.
REQ-041 Never ack on Vcnt=40, then the next line event -> one fetch_abort pulse; fetch_row changes 11->12; fetch_req stays 1.
REQ-042 Drop en for 10 cycles at Hcnt=100 -> Hcnt holds at 100 with no pixel_tick; resumes at 101 after en returns.
REQ-043 Assert rst while BUSY -> all outputs 0 in the same cycle; after release, Hcnt=0 and the FSM is IDLE.
